i2c_scl_gen: RTL
================

I2C_SCL_GEN -- requirements
Module: i2c_scl_gen

Interface
REQ-001 Parameter REF_FREQ, default 50_000_000: reference clock frequency in Hz.
REQ-002 Parameter DEFAULT_FREQ, default 100_000: SCL frequency in Hz after reset.
REQ-003 Parameter CNT_W, default 16: width of the quarter-period count.
REQ-004 Port clock, input, 1: single clock; all logic on posedge.
REQ-005 Port reset, input, 1: reset is asynchronous and active-high.
REQ-006 Port enable, input, 1: run request, level-sensitive.
REQ-007 Port div_load, input, 1: one-cycle strobe that captures div_value.
REQ-008 Port div_value, input, CNT_W: new quarter-period count Q (quarter length is Q+1 clocks).
REQ-009 Port scl_in, input, 1: sensed SCL line level, asynchronous.
REQ-010 Port scl_out, output, 1: SCL drive level (1 = release/high).
REQ-011 Port phase, output, 2: current quarter (0 low-a, 1 low-b, 2 high-a, 3 high-b).
REQ-012 Ports tick_fall, tick_low_mid, tick_rise, tick_high_mid, each output, 1: one-cycle strobes.
REQ-013 Port stretching, output, 1: high while a slave holds SCL low in phase 2.
REQ-014 Port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-015 States: IDLE, RUN, STRETCH.
REQ-016 Quarter register Q resets to REF_FREQ/(4*DEFAULT_FREQ)-1, which is 124 at the defaults.
REQ-017 In RUN, a CNT_W counter counts 0..Q; at Q it wraps to 0 and phase advances by 1, wrapping from 3 to 0.
REQ-018 scl_out is 1 in phases 2 and 3 and in IDLE, and 0 in phases 0 and 1; it is registered with no glitches.
REQ-019 Strobes pulse in the first cycle of each phase: tick_fall on phase 0, tick_low_mid on phase 1, tick_rise on phase 2, tick_high_mid on phase 3.
REQ-020 IDLE->RUN when enable=1; the next cycle is phase 0 with counter 0 and tick_fall asserted.
REQ-021 scl_in passes through a 2-flop synchronizer whose reset value is 1; scl_s is the synchronized value.
REQ-022 In RUN, phase 2: if scl_s=0 and the counter is at 0, go to STRETCH. The counter freezes, stretching=1, and scl_out stays 1.
REQ-023 STRETCH->RUN on the first cycle with scl_s=1. Counting resumes from 0, and tick_rise is not re-pulsed.
REQ-024 Stretch check runs only in phase 2, counter 0; scl_s low in any other phase is ignored.
REQ-025 enable=0 during RUN or STRETCH: the current period completes, and the block goes to IDLE at the phase 3 terminal count. No tick_fall is issued; scl_out stays 1.
REQ-026 enable re-asserted before that terminal count cancels the stop; periods continue without a gap.
REQ-027 div_load captures div_value into a pending register and sets a pending flag. A later div_load before application overwrites the pending value.
REQ-028 In IDLE, a pending value applies to Q on the next cycle. In RUN, it applies at the phase 3 to phase 0 wrap, so a period in progress never changes length.
REQ-029 div_load in the same cycle as an application boundary applies the new value at that boundary.
REQ-030 Q=0 is legal: the SCL period is 4 clocks and every strobe pulses in consecutive cycles.
REQ-031 SCL period without stretching = 4*(Q+1) clocks; high time and low time are each 2*(Q+1) clocks.

Reset
REQ-032 On reset assertion, immediately and independent of clock: state=IDLE, counter=0, phase=3, scl_out=1, all strobes=0, stretching=0, busy=0, synchronizer=1, pending flag=0, Q=default.
REQ-033 Reset mid-period aborts the period without any further strobe. After release, the block waits in IDLE for enable.

Structure
REQ-034 Shared package i2c_pkg holds the state enum, the phase encoding constants, and the default-Q computation function.
REQ-035 One sub-module, sync_2ff (parametrised reset value), implements the scl_in synchronizer.
REQ-036 Target size is 150-300 lines of RTL; no other sub-modules.

Verification
REQ-037 Defaults, enable=1, scl_in=1: scl_out period is 500 clocks with 250 low and 250 high, and strobes are 125 clocks apart in order fall, low_mid, rise, high_mid.
REQ-038 div_value=0 with div_load in IDLE, then enable: period is 4 clocks and one strobe is asserted in every cycle.
REQ-039 Q=9, scl_in held low for 30 clocks from tick_rise: stretching is high for 30 plus synchronizer latency clocks, the high phase is extended by the same amount, and tick_high_mid pulses exactly once.
REQ-040 enable dropped in phase 1: the block runs to the end of phase 3, busy falls, scl_out stays 1, and no further tick_fall occurs.
REQ-041 Q=124, div_load 49 mid-period: the current period is 500 clocks and the next is 200 clocks.
REQ-042 reset asserted mid-phase 0: scl_out is 1 and busy is 0 without waiting for a clock edge; after release with enable=1, the first strobe is tick_fall.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C SCL generator: FSM states, quarter-phase codes
// and the reset-time quarter-length calculation.
package i2c_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_STRETCH = 2'd2;

    localparam logic [1:0] PH_LOW_A  = 2'd0;
    localparam logic [1:0] PH_LOW_B  = 2'd1;
    localparam logic [1:0] PH_HIGH_A = 2'd2;
    localparam logic [1:0] PH_HIGH_B = 2'd3;

    // Quarter count Q such that one SCL period is 4*(Q+1) reference clocks.
    function automatic int default_q(input int ref_freq, input int scl_freq);
        return ref_freq / (4 * scl_freq) - 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a
// selectable reset level so an idle-high line does not look asserted at reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/i2c_scl_gen.sv
// I2C master SCL generator: four equal quarters per period, per-quarter strobes,
// slave clock stretching at the start of the high phase, and glitch-free divisor updates.
module i2c_scl_gen
    import i2c_pkg::*;
#(
    parameter int REF_FREQ     = 50_000_000,
    parameter int DEFAULT_FREQ = 100_000,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_value,
    input  logic             scl_in,
    output logic             scl_out,
    output logic [1:0]       phase,
    output logic             tick_fall,
    output logic             tick_low_mid,
    output logic             tick_rise,
    output logic             tick_high_mid,
    output logic             stretching,
    output logic             busy
);

    localparam logic [CNT_W-1:0] Q_RESET = CNT_W'(default_q(REF_FREQ, DEFAULT_FREQ));

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] q_reg;
    logic [CNT_W-1:0] pend_val;
    logic             pend;
    logic [3:0]       ticks;
    logic             scl_s;

    logic             terminal;
    logic             start_stretch;
    logic             wrap;
    logic             apply_q;
    logic [CNT_W-1:0] nxt_cnt;
    logic [1:0]       nxt_phase;
    logic [3:0]       nxt_ticks;

    sync_2ff #(.RESET_VAL(1'b1)) u_scl_sync (
        .clock (clock),
        .reset (reset),
        .d     (scl_in),
        .q     (scl_s)
    );

    // One counting step; shared by normal running and the exit from a stretch.
    always_comb begin
        terminal      = (cnt == q_reg);
        start_stretch = (state == ST_RUN) && (phase == PH_HIGH_A) && (cnt == '0) && !scl_s;
        wrap          = (state == ST_RUN) && terminal && (phase == PH_HIGH_B);
        apply_q       = (state == ST_IDLE) || wrap;
        nxt_cnt       = cnt + CNT_W'(1);
        nxt_phase     = phase;
        nxt_ticks     = 4'b0000;
        if (terminal) begin
            nxt_cnt   = '0;
            nxt_phase = phase + 2'd1;
            nxt_ticks = 4'b0001 << nxt_phase;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            phase      <= PH_HIGH_B;
            scl_out    <= 1'b1;
            ticks      <= 4'b0000;
            stretching <= 1'b0;
        end else begin
            ticks <= 4'b0000;
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state   <= ST_RUN;
                        cnt     <= '0;
                        phase   <= PH_LOW_A;
                        scl_out <= 1'b0;
                        ticks   <= 4'b0001;
                    end
                end
                ST_RUN: begin
                    if (start_stretch) begin
                        state      <= ST_STRETCH;
                        stretching <= 1'b1;
                    end else if (wrap && !enable) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt     <= nxt_cnt;
                        phase   <= nxt_phase;
                        ticks   <= nxt_ticks;
                        scl_out <= nxt_phase[1];
                    end
                end
                ST_STRETCH: begin
                    // The frozen count resumes where it stopped, so the high
                    // phase grows by exactly the number of stretch cycles.
                    if (scl_s) begin
                        state      <= ST_RUN;
                        stretching <= 1'b0;
                        cnt        <= nxt_cnt;
                        phase      <= nxt_phase;
                        ticks      <= nxt_ticks;
                        scl_out    <= nxt_phase[1];
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    cnt        <= '0;
                    phase      <= PH_HIGH_B;
                    scl_out    <= 1'b1;
                    stretching <= 1'b0;
                end
            endcase
        end
    end

    // New divisors only land between periods so a running period keeps its length.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_reg    <= Q_RESET;
            pend_val <= '0;
            pend     <= 1'b0;
        end else if (apply_q && (div_load || pend)) begin
            q_reg <= div_load ? div_value : pend_val;
            pend  <= 1'b0;
        end else if (div_load) begin
            pend_val <= div_value;
            pend     <= 1'b1;
        end
    end

    assign tick_fall     = ticks[0];
    assign tick_low_mid  = ticks[1];
    assign tick_rise     = ticks[2];
    assign tick_high_mid = ticks[3];
    assign busy          = (state != ST_IDLE);

endmodule
